// File: rtl/axi_pkg.sv
// Shared AXI interconnect encodings: response codes and default-slave FSM states.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

endpackage

// File: rtl/axi_default_slave.sv
// AXI default slave: absorbs unmapped writes and answers every access with DECERR.
// Write and read paths are independent single-outstanding FSMs.
module axi_default_slave
    import axi_pkg::*;
#(
    parameter int IDW  = 4,
    parameter int DW   = 32,
    parameter int LENW = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_awvalid,
    input  logic [IDW-1:0]  i_awid,
    output logic            o_awready,
    input  logic            i_wvalid,
    input  logic            i_wlast,
    output logic            o_wready,
    output logic            o_bvalid,
    output logic [IDW-1:0]  o_bid,
    output logic [1:0]      o_bresp,
    input  logic            i_bready,
    input  logic            i_arvalid,
    input  logic [IDW-1:0]  i_arid,
    input  logic [LENW-1:0] i_arlen,
    output logic            o_arready,
    output logic            o_rvalid,
    output logic [IDW-1:0]  o_rid,
    output logic [DW-1:0]   o_rdata,
    output logic [1:0]      o_rresp,
    output logic            o_rlast,
    input  logic            i_rready
);

    w_state_t        w_state, w_state_nxt;
    r_state_t        r_state, r_state_nxt;
    logic [IDW-1:0]  bid_q;
    logic [IDW-1:0]  rid_q;
    logic [LENW-1:0] cnt_q;

    // ---------------- write path ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w_state <= W_IDLE;
            bid_q   <= '0;
        end else begin
            w_state <= w_state_nxt;
            if (w_state == W_IDLE && i_awvalid)
                bid_q <= i_awid;
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        o_awready   = 1'b0;
        o_wready    = 1'b0;
        o_bvalid    = 1'b0;
        case (w_state)
            W_IDLE: begin
                o_awready = 1'b1;
                if (i_awvalid) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                o_wready = 1'b1;
                if (i_wvalid && i_wlast) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                o_bvalid = 1'b1;
                if (i_bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign o_bid   = bid_q;
    assign o_bresp = RESP_DECERR;

    // ---------------- read path ----------------
    // cnt_q holds beats remaining minus one; it stops at zero on the last beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= R_IDLE;
            rid_q   <= '0;
            cnt_q   <= '0;
        end else begin
            r_state <= r_state_nxt;
            if (r_state == R_IDLE && i_arvalid) begin
                rid_q <= i_arid;
                cnt_q <= i_arlen;
            end else if (r_state == R_DATA && i_rready && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        o_arready   = 1'b0;
        o_rvalid    = 1'b0;
        o_rlast     = 1'b0;
        case (r_state)
            R_IDLE: begin
                o_arready = 1'b1;
                if (i_arvalid) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                o_rvalid = 1'b1;
                o_rlast  = (cnt_q == '0);
                if (i_rready && o_rlast) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    assign o_rid   = rid_q;
    assign o_rdata = '0;
    assign o_rresp = RESP_DECERR;

endmodule

// File: tb/tb_axi_default_slave.sv
// Directed bench for axi_default_slave: handshake latency, DECERR payloads, stalls, reset.
module tb_axi_default_slave;

    localparam int IDW  = 4;
    localparam int DW   = 32;
    localparam int LENW = 8;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic            i_awvalid;
    logic [IDW-1:0]  i_awid;
    logic            o_awready;
    logic            i_wvalid;
    logic            i_wlast;
    logic            o_wready;
    logic            o_bvalid;
    logic [IDW-1:0]  o_bid;
    logic [1:0]      o_bresp;
    logic            i_bready;
    logic            i_arvalid;
    logic [IDW-1:0]  i_arid;
    logic [LENW-1:0] i_arlen;
    logic            o_arready;
    logic            o_rvalid;
    logic [IDW-1:0]  o_rid;
    logic [DW-1:0]   o_rdata;
    logic [1:0]      o_rresp;
    logic            o_rlast;
    logic            i_rready;

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    axi_default_slave #(.IDW(IDW), .DW(DW), .LENW(LENW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_awvalid(i_awvalid), .i_awid(i_awid), .o_awready(o_awready),
        .i_wvalid(i_wvalid), .i_wlast(i_wlast), .o_wready(o_wready),
        .o_bvalid(o_bvalid), .o_bid(o_bid), .o_bresp(o_bresp), .i_bready(i_bready),
        .i_arvalid(i_arvalid), .i_arid(i_arid), .i_arlen(i_arlen), .o_arready(o_arready),
        .o_rvalid(o_rvalid), .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp),
        .o_rlast(o_rlast), .i_rready(i_rready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int beats, rlast_beat, stall_bad, done;
        logic            stalled;
        logic [IDW-1:0]  s_rid;
        logic [DW-1:0]   s_rdata;
        logic [1:0]      s_rresp;
        logic            s_rlast;

        i_rst_n = 1'b0;
        i_awvalid = 1'b0; i_awid = '0; i_wvalid = 1'b0; i_wlast = 1'b0; i_bready = 1'b0;
        i_arvalid = 1'b0; i_arid = '0; i_arlen = '0; i_rready = 1'b0;
        #1;
        chk("rst_awready", o_awready, 1);
        chk("rst_arready", o_arready, 1);
        chk("rst_wready",  o_wready,  0);
        chk("rst_bvalid",  o_bvalid,  0);
        chk("rst_rvalid",  o_rvalid,  0);
        chk("rst_rlast",   o_rlast,   0);
        step(); step();
        i_rst_n = 1'b1;
        step();

        // write: AW id=3, 4 beats, DECERR response
        i_awvalid = 1'b1; i_awid = 4'd3;
        chk("w1_awready_idle", o_awready, 1);
        step();
        i_awvalid = 1'b0;
        chk("w1_wready_after_aw", o_wready, 1);
        chk("w1_awready_busy", o_awready, 0);
        for (int i = 0; i < 4; i++) begin
            i_wvalid = 1'b1; i_wlast = (i == 3);
            chk($sformatf("w1_wready_beat%0d", i), o_wready, 1);
            chk($sformatf("w1_bvalid_beat%0d", i), o_bvalid, 0);
            step();
        end
        i_wvalid = 1'b0; i_wlast = 1'b0;
        chk("w1_bvalid", o_bvalid, 1);
        chk("w1_bid", o_bid, 3);
        chk("w1_bresp", o_bresp, 2'b11);
        chk("w1_wready_resp", o_wready, 0);
        step();
        chk("w1_bvalid_held", o_bvalid, 1);
        chk("w1_bid_held", o_bid, 3);
        i_bready = 1'b1;
        step();
        i_bready = 1'b0;
        chk("w1_bvalid_done", o_bvalid, 0);
        chk("w1_awready_back", o_awready, 1);

        // read: single beat
        i_arvalid = 1'b1; i_arid = 4'd5; i_arlen = 8'd0; i_rready = 1'b1;
        step();
        i_arvalid = 1'b0;
        chk("r1_rvalid", o_rvalid, 1);
        chk("r1_rid", o_rid, 5);
        chk("r1_rdata", o_rdata, 0);
        chk("r1_rresp", o_rresp, 2'b11);
        chk("r1_rlast", o_rlast, 1);
        chk("r1_arready_busy", o_arready, 0);
        step();
        i_rready = 1'b0;
        chk("r1_rvalid_done", o_rvalid, 0);
        chk("r1_arready_back", o_arready, 1);

        // read: 256 beats with rready toggling
        i_arvalid = 1'b1; i_arid = 4'd9; i_arlen = 8'hFF;
        step();
        i_arvalid = 1'b0;
        beats = 0; rlast_beat = 0; stall_bad = 0; done = 0; stalled = 1'b0;
        s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0;
        for (int cyc = 0; cyc < 1000 && done == 0; cyc++) begin
            i_rready = (cyc % 2 == 0);
            if (stalled && (o_rid !== s_rid || o_rdata !== s_rdata ||
                            o_rresp !== s_rresp || o_rlast !== s_rlast || o_rvalid !== 1'b1))
                stall_bad++;
            stalled = 1'b0;
            if (o_rvalid && i_rready) begin
                beats++;
                if (o_rlast) begin
                    if (rlast_beat == 0) rlast_beat = beats;
                    done = 1;
                end
            end else if (o_rvalid) begin
                stalled = 1'b1;
                s_rid = o_rid; s_rdata = o_rdata; s_rresp = o_rresp; s_rlast = o_rlast;
            end
            step();
        end
        i_rready = 1'b0;
        chk("r256_done", done, 1);
        chk("r256_beats", beats, 256);
        chk("r256_rlast_beat", rlast_beat, 256);
        chk("r256_stall_stable", stall_bad, 0);
        chk("r256_rvalid_done", o_rvalid, 0);

        // write: W beat presented before AW stalls and is consumed exactly once
        i_wvalid = 1'b1; i_wlast = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("w2_wready_pre%0d", i), o_wready, 0);
            step();
        end
        chk("w2_bvalid_pre", o_bvalid, 0);
        i_awvalid = 1'b1; i_awid = 4'd6;
        chk("w2_wready_at_aw", o_wready, 0);
        step();
        i_awvalid = 1'b0;
        chk("w2_wready_after_aw", o_wready, 1);
        chk("w2_bvalid_before_w", o_bvalid, 0);
        step();
        i_wvalid = 1'b0; i_wlast = 1'b0;
        chk("w2_bvalid", o_bvalid, 1);
        chk("w2_bid", o_bid, 6);
        i_bready = 1'b1;
        step();
        i_bready = 1'b0;
        chk("w2_bvalid_done", o_bvalid, 0);

        // simultaneous AW and AR, both responses back-pressured
        i_awvalid = 1'b1; i_awid = 4'd2; i_arvalid = 1'b1; i_arid = 4'd7; i_arlen = 8'd0;
        chk("sim_awready", o_awready, 1);
        chk("sim_arready", o_arready, 1);
        step();
        i_awvalid = 1'b0; i_arvalid = 1'b0;
        i_wvalid = 1'b1; i_wlast = 1'b1;
        chk("sim_rvalid", o_rvalid, 1);
        chk("sim_wready", o_wready, 1);
        step();
        i_wvalid = 1'b0; i_wlast = 1'b0;
        i_awvalid = 1'b1; i_awid = 4'd1; i_arvalid = 1'b1; i_arid = 4'd1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("sim_bvalid%0d", i), o_bvalid, 1);
            chk($sformatf("sim_rvalid%0d", i), o_rvalid, 1);
            chk($sformatf("sim_bid%0d", i), o_bid, 2);
            chk($sformatf("sim_rid%0d", i), o_rid, 7);
            chk($sformatf("sim_awready%0d", i), o_awready, 0);
            chk($sformatf("sim_arready%0d", i), o_arready, 0);
            step();
        end
        i_awvalid = 1'b0; i_arvalid = 1'b0;
        i_bready = 1'b1; i_rready = 1'b1;
        step();
        i_bready = 1'b0; i_rready = 1'b0;
        chk("sim_bvalid_done", o_bvalid, 0);
        chk("sim_rvalid_done", o_rvalid, 0);

        // reset mid-burst, then a fresh 2-beat read
        i_arvalid = 1'b1; i_arid = 4'd1; i_arlen = 8'd7;
        step();
        i_arvalid = 1'b0; i_rready = 1'b1;
        step();
        chk("rst_mid_rvalid_pre", o_rvalid, 1);
        chk("rst_mid_rlast_pre", o_rlast, 0);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("rst_mid_rvalid", o_rvalid, 0);
        chk("rst_mid_rlast", o_rlast, 0);
        chk("rst_mid_arready", o_arready, 1);
        chk("rst_mid_awready", o_awready, 1);
        chk("rst_mid_rid", o_rid, 0);
        step();
        i_rst_n = 1'b1;
        i_arvalid = 1'b1; i_arid = 4'd4; i_arlen = 8'd1;
        step();
        i_arvalid = 1'b0;
        beats = 0; rlast_beat = 0; done = 0;
        for (int cyc = 0; cyc < 10 && done == 0; cyc++) begin
            if (o_rvalid && i_rready) begin
                beats++;
                chk($sformatf("rst_post_rid%0d", beats), o_rid, 4);
                if (o_rlast) begin
                    rlast_beat = beats;
                    done = 1;
                end
            end
            step();
        end
        i_rready = 1'b0;
        chk("rst_post_done", done, 1);
        chk("rst_post_beats", beats, 2);
        chk("rst_post_rlast_beat", rlast_beat, 2);
        chk("rst_post_rvalid_done", o_rvalid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
